pattern_tx_sequencer: RTL

- Sequences the lane pattern transmitter (LFSR / per-lane-ID / scrambler generator) on behalf of two link-training requesters: MBINIT on port 0 and MBTRAIN on port 1.
- Arbitrates between the requesters round-robin and drives the generator's 2-bit state and scramble-enable.
- Counts repetitions and watches the generator's done pulse, with a timeout.
- Returns a one-cycle ack carrying a pass/timeout status to the granted requester.

---
 rtl/pattern_seq_pkg.sv | 33 +++
 rtl/pattern_tx_sequencer_if.sv | 28 ++
 rtl/pattern_seq_rr_arb.sv | 24 ++
 rtl/pattern_tx_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// Shared encodings for the pattern transmitter sequencer: generator states,
// requester commands, completion status and the sequencer FSM state type.
package pattern_seq_pkg;

    localparam logic [1:0] PAT_IDLE     = 2'b00;
    localparam logic [1:0] PAT_CLEAR    = 2'b01;
    localparam logic [1:0] PAT_LFSR     = 2'b10;
    localparam logic [1:0] PAT_PER_LANE = 2'b11;

    localparam logic [1:0] CMD_LFSR     = 2'b00;
    localparam logic [1:0] CMD_PER_LANE = 2'b01;
    localparam logic [1:0] CMD_SCRAMBLE = 2'b10;
    localparam logic [1:0] CMD_RSVD     = 2'b11;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_TIMEOUT   = 2'b01;
    localparam logic [1:0] ST_ABORT     = 2'b10;
    localparam logic [1:0] ST_BAD_CMD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_ACK   = 3'd4
    } seq_state_e;

    // Scrambling rides on the LFSR generator state; only PER_LANE_ID differs.
    function automatic logic [1:0] run_pat(input logic [1:0] cmd);
        return (cmd == CMD_PER_LANE) ? PAT_PER_LANE : PAT_LFSR;
    endfunction

endpackage

// File: rtl/pattern_tx_sequencer_if.sv
// Requester / generator bundle for the pattern transmitter sequencer.
// The master side is the requesters plus generator; the slave side is the sequencer.
interface pattern_tx_sequencer_if #(parameter int REP_W = 4);
    logic             i_req0;
    logic             i_req1;
    logic [1:0]       i_cmd0;
    logic [1:0]       i_cmd1;
    logic [REP_W-1:0] i_reps0;
    logic [REP_W-1:0] i_reps1;
    logic             i_abort;
    logic             i_pat_done;
    logic [1:0]       o_pat_state;
    logic             o_scramble_en;
    logic             o_ack0;
    logic             o_ack1;
    logic [1:0]       o_status;
    logic             o_busy;

    modport master (
        output i_req0, i_req1, i_cmd0, i_cmd1, i_reps0, i_reps1, i_abort, i_pat_done,
        input  o_pat_state, o_scramble_en, o_ack0, o_ack1, o_status, o_busy
    );

    modport slave (
        input  i_req0, i_req1, i_cmd0, i_cmd1, i_reps0, i_reps1, i_abort, i_pat_done,
        output o_pat_state, o_scramble_en, o_ack0, o_ack1, o_status, o_busy
    );
endinterface

// File: rtl/pattern_seq_rr_arb.sv
// Two-requester round-robin arbiter. The pointer names the favoured requester;
// on advance it moves to the one that was not just served.
module pattern_seq_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_idx
);
    logic ptr_q;

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= 1'b0;
        else if (adv)
            ptr_q <= ~last;
    end

    assign gnt_vld = |req;
    assign gnt_idx = req[ptr_q] ? ptr_q : ~ptr_q;

endmodule

// File: rtl/pattern_tx_sequencer.sv
// Drives the lane pattern generator for the MBINIT (port 0) and MBTRAIN (port 1)
// requesters. Optional run counters under PAT_SEQ_PERF_CNT_EN.
module pattern_tx_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int REP_W          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pattern_tx_sequencer_if.slave bus
`ifdef PAT_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]           o_runs_ok,
    output logic [15:0]           o_runs_fail
`endif
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e       state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [1:0]       status_q, status_d;
    logic [1:0]       pat_q, pat_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             owner_q, owner_d;
    logic             scr_q, scr_d;
    logic             ack0_q, ack1_q;

    logic             gnt_vld, gnt_idx, adv;
    logic [1:0]       req;
    logic [1:0]       sel_cmd;
    logic [REP_W-1:0] sel_reps;

    assign req      = {bus.i_req1, bus.i_req0};
    assign sel_cmd  = gnt_idx ? bus.i_cmd1  : bus.i_cmd0;
    assign sel_reps = gnt_idx ? bus.i_reps1 : bus.i_reps0;

    pattern_seq_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .adv     (adv),
        .last    (owner_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        to_cnt_d  = to_cnt_q;
        owner_d   = owner_q;
        status_d  = status_q;
        adv       = 1'b0;
        pat_d     = PAT_IDLE;
        scr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    owner_d   = gnt_idx;
                    cmd_d     = sel_cmd;
                    reps_d    = (sel_reps == '0) ? REP_W'(1) : sel_reps;
                    rep_cnt_d = '0;
                    to_cnt_d  = '0;
                    if (sel_cmd == CMD_RSVD) begin
                        state_d  = S_ACK;
                        status_d = ST_BAD_CMD;
                    end else begin
                        state_d  = S_CLEAR;
                    end
                end
            end
            S_CLEAR: state_d = S_RUN;
            S_RUN: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A done on the final allowed cycle still counts as a pass.
                if (bus.i_pat_done) begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                    state_d   = S_GAP;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_ACK;
                    status_d = ST_TIMEOUT;
                end
            end
            S_GAP: begin
                to_cnt_d = '0;
                if (rep_cnt_q == reps_q) begin
                    state_d  = S_ACK;
                    status_d = ST_OK;
                end else begin
                    state_d  = S_CLEAR;
                end
            end
            S_ACK: begin
                adv     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over done/timeout; an ack already in flight is left alone.
        if (bus.i_abort && (state_q inside {S_CLEAR, S_RUN, S_GAP})) begin
            state_d  = S_ACK;
            status_d = ST_ABORT;
        end

        case (state_d)
            S_CLEAR: pat_d = PAT_CLEAR;
            S_RUN: begin
                pat_d = run_pat(cmd_d);
                scr_d = (cmd_d == CMD_SCRAMBLE);
            end
            default: pat_d = PAT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_LFSR;
            status_q  <= ST_OK;
            pat_q     <= PAT_IDLE;
            reps_q    <= '0;
            rep_cnt_q <= '0;
            to_cnt_q  <= '0;
            owner_q   <= 1'b0;
            scr_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            status_q  <= status_d;
            pat_q     <= pat_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            to_cnt_q  <= to_cnt_d;
            owner_q   <= owner_d;
            scr_q     <= scr_d;
            ack0_q    <= (state_d == S_ACK) && !owner_d;
            ack1_q    <= (state_d == S_ACK) &&  owner_d;
        end
    end

    assign bus.o_pat_state   = pat_q;
    assign bus.o_scramble_en = scr_q;
    assign bus.o_ack0        = ack0_q;
    assign bus.o_ack1        = ack1_q;
    assign bus.o_status      = status_q;
    assign bus.o_busy        = (state_q != S_IDLE);

`ifdef PAT_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_runs_ok   <= '0;
            o_runs_fail <= '0;
        end else if (state_q == S_ACK) begin
            if (status_q == ST_OK) begin
                if (o_runs_ok != 16'hFFFF) o_runs_ok <= o_runs_ok + 1'b1;
            end else begin
                if (o_runs_fail != 16'hFFFF) o_runs_fail <= o_runs_fail + 1'b1;
            end
        end
    end
`endif

endmodule
